// File: rtl/ann_mac_sequencer.sv
// Sequenced feed-forward evaluator for a 2-2-1 XOR network: one shared signed
// multiplier/accumulator computes h0, h1 and then y from a 9-entry weight file.
module ann_mac_sequencer #(
    parameter int W     = 8,
    parameter int FRAC  = 4,
    parameter int ACC_W = 2*W+2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    input  logic         wr_en,
    input  logic [3:0]   wr_addr,
    input  logic [W-1:0] wr_data,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] h0,
    output logic [W-1:0] h1,
    output logic [W-1:0] y
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_DONE} state_t;

    localparam logic signed [W-1:0]     BIAS    = W'(32'd1 << FRAC);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((32'd1 << (W-1)) - 32'd1);

    state_t                  state_r, state_s;
    logic [1:0]              n_r, k_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [W-1:0]     w_r     [9];
    logic signed [W-1:0]     run_w_r [9];
    logic signed [W-1:0]     x0_r, x1_r;
    logic [W-1:0]            h0_r, h1_r, y_r;
    logic                    busy_r, done_r;
    logic                    idle_s, accept_s;
    logic [3:0]              widx_s;
    logic signed [W-1:0]     operand_s;
    logic signed [2*W-1:0]   prod_s;
    logic signed [ACC_W-1:0] acc_nx_s;
    logic [W-1:0]            act_s;

    // Arithmetic shift back to Q(FRAC), then ReLU and positive saturation.
    function automatic logic [W-1:0] relu_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        r = acc >>> FRAC;
        if (r < $signed({ACC_W{1'b0}})) begin
            relu_sat = '0;
        end else if (r > SAT_MAX) begin
            relu_sat = SAT_MAX[W-1:0];
        end else begin
            relu_sat = r[W-1:0];
        end
    endfunction

    assign idle_s   = (state_r == S_IDLE) || (state_r == S_DONE);
    assign accept_s = idle_s && start;
    assign widx_s   = {1'b0, n_r, 1'b0} + {2'b00, n_r} + {2'b00, k_r};
    assign prod_s   = run_w_r[widx_s] * operand_s;
    assign acc_nx_s = acc_r + {{(ACC_W-2*W){prod_s[2*W-1]}}, prod_s};
    assign act_s    = relu_sat(acc_r);

    // Operand select: inputs for the hidden layer, hidden activations for y, bias last.
    always_comb begin
        operand_s = BIAS;
        case (k_r)
            2'd0:    operand_s = (n_r == 2'd2) ? $signed(h0_r) : x0_r;
            2'd1:    operand_s = (n_r == 2'd2) ? $signed(h1_r) : x1_r;
            default: operand_s = BIAS;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = start ? S_MAC : S_IDLE;
            S_MAC:   state_s = (k_r == 2'd2) ? S_ACT : S_MAC;
            S_ACT:   state_s = (n_r == 2'd2) ? S_DONE : S_MAC;
            S_DONE:  state_s = start ? S_MAC : S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == S_MAC) || (state_s == S_ACT);
            done_r  <= (state_s == S_DONE);
        end
    end

    // Host weight file; only writable while the sequencer is not running.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) w_r[i] <= '0;
        end else if (idle_s && wr_en && (wr_addr <= 4'd8)) begin
            w_r[wr_addr] <= wr_data;
        end else begin
            w_r <= w_r;
        end
    end

    // Datapath: a run works on a snapshot of the weights taken at the accepting
    // edge, so a write on that same edge only affects the following run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) run_w_r[i] <= '0;
            x0_r  <= '0;
            x1_r  <= '0;
            acc_r <= '0;
            n_r   <= 2'd0;
            k_r   <= 2'd0;
            h0_r  <= '0;
            h1_r  <= '0;
            y_r   <= '0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (accept_s) begin
                        run_w_r <= w_r;
                        x0_r    <= x0;
                        x1_r    <= x1;
                        acc_r   <= '0;
                        n_r     <= 2'd0;
                        k_r     <= 2'd0;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                S_MAC: begin
                    acc_r <= acc_nx_s;
                    k_r   <= (k_r == 2'd2) ? k_r : k_r + 2'd1;
                end
                S_ACT: begin
                    case (n_r)
                        2'd0:    h0_r <= act_s;
                        2'd1:    h1_r <= act_s;
                        default: y_r  <= act_s;
                    endcase
                    acc_r <= '0;
                    k_r   <= 2'd0;
                    n_r   <= (n_r == 2'd2) ? n_r : n_r + 2'd1;
                end
                default: begin
                    acc_r <= '0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign h0   = h0_r;
    assign h1   = h1_r;
    assign y    = y_r;

endmodule

// File: tb/tb_ann_mac_sequencer.sv
// Directed self-checking bench for ann_mac_sequencer using the XOR weight set
// and hand-computed Q4 results.
module tb_ann_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, wr_en, busy, done;
    logic [7:0] x0, x1, wr_data, h0, h1, y;
    logic [3:0] wr_addr;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    ann_mac_sequencer #(.W(8), .FRAC(4), .ACC_W(18)) dut (
        .clk(clk), .rst(rst), .start(start), .x0(x0), .x1(x1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .h0(h0), .h1(h1), .y(y)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = a[3:0];
        wr_data = d[7:0];
        step;
        wr_en   = 1'b0;
    endtask

    task automatic load_xor;
        wr(0, 16); wr(1, 16); wr(2, 0);
        wr(3, 16); wr(4, 16); wr(5, -16);
        wr(6, 16); wr(7, -32); wr(8, 0);
    endtask

    // mode 0: plain; 1: mid-run input/weight/start hazards; 2: w0=0 written on the start edge
    task automatic run(input string tag, input int a, input int b, input int mode,
                       input int eh0, input int eh1, input int ey);
        int lat;
        int stray;
        bit seen;
        lat  = -1;
        seen = 1'b0;
        x0 = a[7:0];
        x1 = b[7:0];
        start = 1'b1;
        if (mode == 2) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'd0;
        end
        step;
        start = 1'b0;
        wr_en = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            if (mode == 1 && c == 3) begin
                x0 = 8'h7f; x1 = 8'h7f;
                wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h80;
            end
            if (mode == 1 && c == 6) start = 1'b1;
            step;
            wr_en = 1'b0;
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        chk({tag, "_latency"}, lat, 12);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_h0"}, h0, eh0);
        chk({tag, "_h1"}, h1, eh1);
        chk({tag, "_y"}, y, ey);
        step;
        chk({tag, "_done_pulse"}, done, 0);
        if (mode == 1) begin
            stray = 0;
            for (int c = 0; c < 15; c++) begin
                step;
                if (done) stray++;
            end
            chk({tag, "_stray_done"}, stray, 0);
        end
    endtask

    initial begin
        int dcnt;
        int dat[4];
        rst = 1'b0; start = 1'b0; wr_en = 1'b0;
        x0 = '0; x1 = '0; wr_addr = '0; wr_data = '0;
        step; step;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_h0", h0, 0);
        chk("rst_h1", h1, 0);
        chk("rst_y", y, 0);
        rst = 1'b1;
        step;

        load_xor;
        run("xor11", 16, 16, 0, 32, 16, 0);
        run("xor10", 16, 0, 0, 16, 0, 16);
        run("xor00", 0, 0, 0, 0, 0, 0);
        run("hazard", 16, 0, 1, 16, 0, 16);
        run("after_hazard", 16, 0, 0, 16, 0, 16);
        run("wr_on_start", 16, 0, 2, 16, 0, 16);
        run("w0_zero", 16, 0, 0, 0, 0, 0);
        wr(0, 16);

        // start held for 30 edges: runs accepted at 0, 13, 26
        dcnt = 0;
        x0 = 8'd16; x1 = 8'd16;
        start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            step;
            if (i == 29) start = 1'b0;
            if (done) begin
                if (dcnt < 4) dat[dcnt] = i;
                dcnt++;
            end
        end
        chk("b2b_count", dcnt, 3);
        chk("b2b_first", dat[0], 12);
        chk("b2b_gap1", dat[1] - dat[0], 13);
        chk("b2b_gap2", dat[2] - dat[1], 13);

        wr(0, 127); wr(1, 127); wr(3, -128); wr(4, 0); wr(5, 0);
        run("sat_relu", 127, 127, 0, 127, 0, 127);

        // reset asserted at E6 of a run
        x0 = 8'd16; x1 = 8'd16;
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (5) step;
        rst = 1'b0;
        step;
        rst = 1'b1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_h0", h0, 0);
        chk("mrst_h1", h1, 0);
        chk("mrst_y", y, 0);
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            step;
            if (done) dcnt++;
        end
        chk("mrst_no_done", dcnt, 0);
        run("post_rst", 16, 16, 0, 0, 0, 0);

        load_xor;
        wr(12, -128);
        run("addr_guard", 16, 0, 0, 16, 0, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ann_mac_sequencer.md
# ann_mac_sequencer

Time-multiplexed feed-forward controller for the 2-2-1 XOR network: one shared signed multiplier and accumulator evaluate hidden neurons h0 and h1, then output neuron y, from a 9-entry weight register file. It sits between the host test logic, which supplies inputs, weights and a `start` strobe, and downstream consumers of `y`. It replaces the per-connection multiplier instances with a single sequenced datapath behind a start/busy/done handshake.

## Interface
- W, 8, data and weight width (signed two's complement, Q format)
- FRAC, 4, fractional bits; 1.0 = 1<<FRAC
- ACC_W, 2*W+2, accumulator width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin evaluation; sampled only in IDLE or DONE
- x0, x1  in  W  network inputs, signed Q(FRAC); captured on the accepting edge
- wr_en  in  1  weight write strobe
- wr_addr  in  4  weight index 0..8; neuron n term k at 3n+k
- wr_data  in  W  signed weight
- busy  out  1  high in MAC/ACT states
- done  out  1  one-cycle pulse; y valid
- h0, h1  out  W  hidden activations from the last run
- y  out  W  network output from the last run

## Operation
- States: IDLE, MAC, ACT, DONE. Counters: neuron n (0..2), term k (0..2).
- IDLE/DONE + start=1: latch x0/x1, clear acc, n=0, k=0, go to MAC. In DONE with start=0, go to IDLE.
- Operands: k=0 uses x0 (n<2) or h0 (n=2); k=1 uses x1 or h1; k=2 uses the bias constant 1<<FRAC.
- MAC, one edge per term: acc += sext(w[3n+k]) * operand, a signed WxW product sign-extended to ACC_W. k=2 goes to ACT; otherwise k++.
- ACT: r = acc >>> FRAC (arithmetic). ReLU: r<0 gives 0. Saturate: r > 2^(W-1)-1 gives 2^(W-1)-1.
  - Write r to h0 (n=0), h1 (n=1) or y (n=2).
  - Clear acc, k=0.
  - n<2: n++ and return to MAC. n=2: go to DONE.
- Weight writes are accepted only in IDLE or DONE. Writes while busy, or with wr_addr>8, are ignored with no side effect.
- A write and a start on the same edge: the write commits and the run uses the old weight for that entry. Writes take effect from the next accepted start.
- start while busy: ignored.
- h0, h1 and y hold their values between runs. They update only in ACT.

## Timing
- Reset (rst=0 at an edge) gives: state IDLE, busy=0, done=0, h0=h1=y=0, acc=0, n=k=0, all weights 0. Reset takes priority over every other event, including mid-run; no partial result is retained.
- Let E0 be the edge that accepts start. MAC updates on E1–E3, E5–E7 and E9–E11; ACT on E4 (h0), E8 (h1) and E12 (y).
- busy is high from after E0 until E12, for 12 cycles. done is high for exactly the one cycle after E12, with busy=0.
- Latency from accepting edge to done: 12 cycles. Back-to-back: start high during the done cycle is accepted at E13, giving a 13-cycle period.
- x0/x1 changes after E0 do not affect the current run.

## Test plan
- XOR weights (W=8, FRAC=4): w0..2=16,16,0; w3..5=16,16,-16; w6..8=16,-32,0.
  - x=(16,16) gives h0=32, h1=16, y=0.
  - x=(16,0) gives h0=16, h1=0, y=16.
  - x=(0,0) gives y=0.
  - done arrives 12 cycles after the accepting edge.
- Saturation and ReLU: w0=w1=127, x=(127,127) gives h0=127. w3=-128, x0=127, others 0, gives h1=0.
- Hazards: during busy, toggle x0 and write wr_addr=0 with data -128. The current y is unchanged vs the golden result, and the next run still sees w0=16.
- Back-to-back and ignore: start held high for 30 cycles gives done pulses exactly 13 cycles apart. A start pulse mid-run gives no extra done.
- Reset mid-run: drive rst=0 at E6, release. busy=0, done=0, h0=h1=y=0, all weights 0 on the next cycle. A new start without rewrites gives y=0.
- Address guard: a write to wr_addr=12 in IDLE leaves all 9 weights unchanged, verified by repeating XOR case (16,0) and getting y=16.
